vga_scan_ctrl: RTL

Display-timing controller that drives a 640x480@60 Hz VGA monitor. It scans the frame with horizontal and vertical counters and presents the current pixel coordinate on `h_addr`/`v_addr` to a combinational pixel-data source. The source returns a 24-bit colour on `vga_data`, which this block registers and drives out as RGB, aligned with `hsync`, `vsync` and `valid`. It sits between any picture or pattern generator and the board's VGA DAC pins.

---
 rtl/vga_scan_if.sv | 26 ++
 rtl/vga_scan_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/vga_scan_if.sv
// Pixel-address / colour / sync bundle between vga_scan_ctrl (master) and
// the pixel source plus DAC side (slave).
interface vga_scan_if;
    logic [23:0] vga_data;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    modport master (
        input  vga_data,
        output h_addr, v_addr, hsync, vsync, valid,
               vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output vga_data,
        input  h_addr, v_addr, hsync, vsync, valid,
               vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan-timing controller: h/v counters, combinational pixel address, one-tick
// registered RGB/sync stage. Define VGA_SCAN_CTRL_CLKDIV_EN to tick every second clk.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clk,
    input  logic        reset,
    vga_scan_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    logic        pix_en;
    logic [9:0]  h_cnt_reg;
    logic [9:0]  v_cnt_reg;
    logic        act;
    logic        h_sync_on;
    logic        v_sync_on;
    logic        origin;
    logic [23:0] rgb_next;
    logic [23:0] rgb_reg;
    logic        valid_reg;
    logic        hsync_reg;
    logic        vsync_reg;
    logic        frame_start_reg;

`ifdef VGA_SCAN_CTRL_CLKDIV_EN
    logic pix_en_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix_en_reg <= 1'b0;
        else       pix_en_reg <= ~pix_en_reg;
    end

    assign pix_en = pix_en_reg;
`else
    assign pix_en = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_en) begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 10'd1;
            end
        end
    end

    assign act       = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    assign h_sync_on = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
    assign v_sync_on = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
    assign origin    = (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);

    assign bus.h_addr = act ? h_cnt_reg : 10'd0;
    assign bus.v_addr = act ? v_cnt_reg : 10'd0;

    // Blank each colour channel outside the visible area so porches/sync carry black.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_next[8*gi +: 8] = act ? bus.vga_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_reg         <= '0;
            valid_reg       <= 1'b0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
        end else if (pix_en) begin
            rgb_reg         <= rgb_next;
            valid_reg       <= act;
            hsync_reg       <= ~h_sync_on;
            vsync_reg       <= ~v_sync_on;
            frame_start_reg <= origin;
        end
    end

    assign bus.vga_r       = rgb_reg[23:16];
    assign bus.vga_g       = rgb_reg[15:8];
    assign bus.vga_b       = rgb_reg[7:0];
    assign bus.valid       = valid_reg;
    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.frame_start = frame_start_reg;
endmodule
